wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of write_data, in_alu_result and mem_rdata.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum cycles spent in LOAD_WAIT before abort (range 1..255).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  execute stage presents an op.
REQ-006 SHALL have port in_ready  out  1  stage accepts op this cycle (transfer = in_valid & in_ready).
REQ-007 SHALL have port in_dst_sel  in  2  destination code: 00 none, 01 rs, 10 rt, 11 r31.
REQ-008 SHALL have port in_is_load  in  1  result comes from data memory, not ALU.
REQ-009 SHALL have port in_alu_result  in  DATA_W  ALU/link result.
REQ-010 SHALL have port mem_rvalid  in  1  load data valid, one-cycle pulse.
REQ-011 SHALL have port mem_rdata  in  DATA_W  load data, qualified by mem_rvalid.
REQ-012 SHALL have port reg_write  out  2  register-file write code, same encoding as in_dst_sel.
REQ-013 SHALL have port write_data  out  DATA_W  register-file write value.
REQ-014 SHALL have port load_err  out  1  sticky flag: a load timed out.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_WAIT, WRITE.
REQ-016 SHALL drive in_ready=1 in IDLE and WRITE, 0 in LOAD_WAIT.
REQ-017 SHALL, on transfer with in_is_load=0 and in_dst_sel!=00, latch in_alu_result and dst, go to WRITE; reg_write asserted exactly one cycle after transfer.
REQ-018 SHALL, on transfer with in_is_load=0 and in_dst_sel=00, retire the op with no write and go to (or stay in) IDLE.
REQ-019 SHALL, on transfer with in_is_load=1, latch dst, clear timeout counter, go to LOAD_WAIT.
REQ-020 SHALL, in LOAD_WAIT on mem_rvalid, latch mem_rdata and go to WRITE (dst!=00) or IDLE (dst=00).
REQ-021 SHALL, in LOAD_WAIT, increment an 8-bit counter each cycle without mem_rvalid; on reaching MEM_TIMEOUT set load_err, drop the write, go to IDLE.
REQ-022 SHALL drive reg_write=latched dst and write_data=latched value only in WRITE; reg_write=00 in all other states.
REQ-023 SHALL, in WRITE, accept a new op in the same cycle (back-to-back), next state chosen by REQ-017..019; otherwise return to IDLE.
REQ-024 SHALL ignore mem_rvalid outside LOAD_WAIT.
REQ-025 SHALL, when mem_rvalid and timeout coincide in the same cycle, take the data (REQ-020) and not set load_err.
REQ-026 SHALL hold write_data at its last value when reg_write=00.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, reg_write=00, write_data=0, load_err=0, counter=0, in_ready=0 asynchronously.
REQ-028 SHALL, when reset asserts mid-load or mid-write, abandon the op with no write after release.
REQ-029 SHALL clear load_err only by reset.

Configuration
REQ-030 SHALL, with macro WB_FWD_EN defined, add outputs fwd_valid (1), fwd_dst_sel (2) and fwd_data (DATA_W) equal to reg_write!=00, reg_write and write_data in the same cycle.
REQ-031 SHALL, without WB_FWD_EN, omit those ports; all other behaviour identical.

Structure
REQ-032 SHALL take dst-select encodings (DST_NONE/RS/RT/R31) and the FSM state type from shared package kgp_pkg.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 ALU op: transfer dst=01, result 0x0000_00A5 at cycle N -> reg_write=01, write_data=0x0000_00A5 at N+1 only.
REQ-035 Load: transfer dst=10, mem_rvalid with 0xDEAD_BEEF 3 cycles later -> in_ready=0 for 3 cycles, reg_write=10, write_data=0xDEAD_BEEF next cycle.
REQ-036 Back-to-back: three ALU ops dst 01,10,11 on consecutive cycles -> three consecutive one-cycle writes, in_ready never drops.
REQ-037 Timeout: MEM_TIMEOUT=4, load with no mem_rvalid -> after 4 cycles load_err=1, no write, in_ready=1; later mem_rvalid ignored.
REQ-038 Reset mid-load: rst low during LOAD_WAIT, then mem_rvalid after release -> outputs reset values, no write.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared encodings for the writeback stage: destination-select codes and FSM state type.
package kgp_pkg;

    typedef enum logic [1:0] {
        DST_NONE = 2'b00,
        DST_RS   = 2'b01,
        DST_RT   = 2'b10,
        DST_R31  = 2'b11
    } dst_sel_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        WRITE     = 2'b10
    } wb_state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and waits (with timeout) for load data.
// Define WB_FWD_EN to expose the fwd_valid/fwd_dst_sel/fwd_data forwarding ports.
module wb_stage
    import kgp_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_dst_sel,
    input  logic              in_is_load,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        reg_write,
    output logic [DATA_W-1:0] write_data,
    output logic              load_err
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [1:0]        fwd_dst_sel,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

    wb_state_e         state, state_d;
    logic [1:0]        dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              err_set;
    logic              accept;

    // in_ready must also read 0 while reset is held, not just after the first edge.
    assign in_ready = rst && (state != LOAD_WAIT);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        dst_d   = dst_q;
        data_d  = data_q;
        cnt_d   = cnt;
        err_set = 1'b0;
        case (state)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (accept) begin
                    if (in_is_load) begin
                        dst_d   = in_dst_sel;
                        cnt_d   = '0;
                        state_d = LOAD_WAIT;
                    end else if (in_dst_sel != DST_NONE) begin
                        dst_d   = in_dst_sel;
                        data_d  = in_alu_result;
                        state_d = WRITE;
                    end
                end
            end
            LOAD_WAIT: begin
                // Data wins over a timeout landing in the same cycle.
                if (mem_rvalid) begin
                    if (dst_q != DST_NONE) begin
                        data_d  = mem_rdata;
                        state_d = WRITE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                    if (cnt_d == TMO) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // data_q only moves on the way into WRITE, so write_data holds while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst_q    <= DST_NONE;
            data_q   <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
        end else begin
            dst_q  <= dst_d;
            data_q <= data_d;
            cnt    <= cnt_d;
            if (err_set) load_err <= 1'b1;
        end
    end

    assign reg_write  = (state == WRITE) ? dst_q : DST_NONE;
    assign write_data = data_q;

`ifdef WB_FWD_EN
    assign fwd_valid   = (reg_write != DST_NONE);
    assign fwd_dst_sel = reg_write;
    assign fwd_data    = write_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes are queued with their cycle and matched by a monitor.
module tb_wb_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_dst_sel;
    logic          in_is_load;
    logic [DW-1:0] in_alu_result;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    reg_write;
    logic [DW-1:0] write_data;
    logic          load_err;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [1:0]    fwd_dst_sel;
    logic [DW-1:0] fwd_data;
`endif

    wb_stage #(.DATA_W(DW), .MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dst_sel    (in_dst_sel),
        .in_is_load    (in_is_load),
        .in_alu_result (in_alu_result),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .reg_write     (reg_write),
        .write_data    (write_data),
        .load_err      (load_err)
`ifdef WB_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_dst_sel   (fwd_dst_sel),
        .fwd_data      (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    dst;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cyc = '0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] dst, input logic [DW-1:0] data);
        exp_t e;
        e.dst  = dst;
        e.data = data;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic drive_op(input logic ld, input logic [1:0] dst, input logic [DW-1:0] res);
        in_valid      = 1'b1;
        in_is_load    = ld;
        in_dst_sel    = dst;
        in_alu_result = res;
    endtask

    task automatic quiet();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        in_dst_sel = 2'b00;
        mem_rvalid = 1'b0;
    endtask

    // Every write the DUT makes must match the oldest queued write, in the expected cycle.
    always @(negedge clk) begin
        if (rst && reg_write != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {62'd0, reg_write}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_dst", {62'd0, reg_write}, {62'd0, e.dst});
                chk("wr_data", {32'd0, write_data}, {32'd0, e.data});
                chk("wr_cycle", {32'd0, cyc}, {32'd0, e.cyc});
            end
        end
`ifdef WB_FWD_EN
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, reg_write != 2'b00});
        chk("fwd_dst", {62'd0, fwd_dst_sel}, {62'd0, reg_write});
        chk("fwd_data", {32'd0, fwd_data}, {32'd0, write_data});
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] r;
        rst = 1'b0;
        in_alu_result = '0;
        mem_rdata = '0;
        quiet();
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_regwr", {62'd0, reg_write}, 64'd0);
        chk("rst_wdata", {32'd0, write_data}, 64'd0);
        chk("rst_err", {63'd0, load_err}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", {63'd0, in_ready}, 64'd1);

        // Single ALU op: write exactly one cycle later, then nothing.
        drive_op(1'b0, 2'b01, 32'h0000_00A5);
        push(2'b01, 32'h0000_00A5);
        @(negedge clk);
        quiet();
        @(negedge clk);
        chk("alu_one_cycle", {62'd0, reg_write}, 64'd0);

        // Three back-to-back ALU ops.
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            drive_op(1'b0, 2'(i + 1), r);
            push(2'(i + 1), r);
            @(negedge clk);
            chk("b2b_ready", {63'd0, in_ready}, 64'd1);
        end
        quiet();
        @(negedge clk);

        // dst=none ALU op retires silently.
        drive_op(1'b0, 2'b00, 32'h1234_5678);
        @(negedge clk);
        quiet();
        chk("none_ready", {63'd0, in_ready}, 64'd1);
        chk("none_hold", {32'd0, write_data}, {32'd0, r});

        // Load: three cycles of backpressure, then data written.
        drive_op(1'b1, 2'b10, 32'hFFFF_FFFF);
        @(negedge clk);
        quiet();
        chk("ld_ready0", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("ld_ready1", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("ld_ready2", {63'd0, in_ready}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        push(2'b10, 32'hDEAD_BEEF);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("ld_wr_ready", {63'd0, in_ready}, 64'd1);

        // Stray mem_rvalid while idle is ignored.
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_hold", {32'd0, write_data}, 64'hDEAD_BEEF);

        // Load with dst=none: data consumed, no write, write_data held.
        drive_op(1'b1, 2'b00, 32'h0);
        @(negedge clk);
        quiet();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAAAA_0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("ldnone_ready", {63'd0, in_ready}, 64'd1);
        chk("ldnone_hold", {32'd0, write_data}, 64'hDEAD_BEEF);

        // ALU write followed immediately by a load accepted in WRITE;
        // its data arrives in the last cycle before timeout.
        drive_op(1'b0, 2'b01, 32'h0000_0011);
        push(2'b01, 32'h0000_0011);
        @(negedge clk);
        drive_op(1'b1, 2'b11, 32'h0);
        @(negedge clk);
        quiet();
        repeat (3) @(negedge clk);
        chk("edge_ready", {63'd0, in_ready}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        push(2'b11, 32'hCAFE_F00D);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("edge_no_err", {63'd0, load_err}, 64'd0);

        // Timeout: four wait cycles then abort with load_err.
        drive_op(1'b1, 2'b01, 32'h0);
        @(negedge clk);
        quiet();
        repeat (3) @(negedge clk);
        chk("tmo_wait_ready", {63'd0, in_ready}, 64'd0);
        chk("tmo_wait_err", {63'd0, load_err}, 64'd0);
        @(negedge clk);
        chk("tmo_err", {63'd0, load_err}, 64'd1);
        chk("tmo_ready", {63'd0, in_ready}, 64'd1);
        chk("tmo_regwr", {62'd0, reg_write}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("tmo_late_hold", {32'd0, write_data}, 64'hCAFE_F00D);
        drive_op(1'b0, 2'b10, 32'h0000_0022);
        push(2'b10, 32'h0000_0022);
        @(negedge clk);
        quiet();
        @(negedge clk);
        chk("err_sticky", {63'd0, load_err}, 64'd1);

        // Reset during LOAD_WAIT abandons the load.
        drive_op(1'b1, 2'b10, 32'h0);
        @(negedge clk);
        quiet();
        rst = 1'b0;
        #1;
        chk("mrst_ready", {63'd0, in_ready}, 64'd0);
        chk("mrst_regwr", {62'd0, reg_write}, 64'd0);
        chk("mrst_wdata", {32'd0, write_data}, 64'd0);
        chk("mrst_err", {63'd0, load_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("mrst_after_ready", {63'd0, in_ready}, 64'd1);
        chk("mrst_after_wdata", {32'd0, write_data}, 64'd0);
        repeat (2) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
